// File: rtl/arb_grant_lock_pkg.sv
// Shared constants and state type for the grant-lock requester block.
package arb_grant_lock_pkg;

  localparam int unsigned DEF_NUM_PORTS  = 8;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LEN_W      = 4;
  localparam int unsigned DEF_PORT_IDX_W = $clog2(DEF_NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/arb_grant_lock_if.sv
// Client, arbiter and shared-bus signals of the grant-lock block.
interface arb_grant_lock_if
  import arb_grant_lock_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LEN_W     = DEF_LEN_W
);
  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]        cli_valid_i;
  logic [NUM_PORTS*LEN_W-1:0]  cli_len_i;
  logic [NUM_PORTS*DATA_W-1:0] cli_data_i;
  logic [NUM_PORTS-1:0]        cli_ready_o;
  logic [NUM_PORTS-1:0]        arb_req_o;
  logic [NUM_PORTS-1:0]        arb_gnt_i;
  logic                        bus_valid_o;
  logic [DATA_W-1:0]           bus_data_o;
  logic [IDX_W-1:0]            bus_port_o;
  logic                        bus_last_o;
  logic                        bus_ready_i;
  logic                        err_o;

  // Environment side: clients, arbiter and bus sink.
  modport master (
    output cli_valid_i, cli_len_i, cli_data_i, arb_gnt_i, bus_ready_i,
    input  cli_ready_o, arb_req_o, bus_valid_o, bus_data_o, bus_port_o,
           bus_last_o, err_o
  );

  // Grant-lock block side.
  modport slave (
    input  cli_valid_i, cli_len_i, cli_data_i, arb_gnt_i, bus_ready_i,
    output cli_ready_o, arb_req_o, bus_valid_o, bus_data_o, bus_port_o,
           bus_last_o, err_o
  );

endinterface

// File: rtl/arb_grant_lock_oh2idx.sv
// One-hot to binary index encoder with a strict one-hot flag.
module arb_grant_lock_oh2idx #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         oh,
  output logic [$clog2(N)-1:0] idx,
  output logic                 is_onehot
);

  localparam int unsigned IW = $clog2(N);

  // OR of set-bit indices; exact only when the input is one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (oh[i]) begin
        idx = idx | IW'(i);
      end
    end
  end

  assign is_onehot = (oh != '0) && ((oh & (oh - N'(1))) == '0);

endmodule

// File: rtl/arb_grant_lock.sv
// Requester-side grant lock: captures an arbiter grant, holds it for one whole
// multi-beat burst and muxes the owning client onto the shared valid/ready bus.
module arb_grant_lock
  import arb_grant_lock_pkg::*;
#(
  parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LEN_W     = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  arb_grant_lock_if.slave  bif
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  state_e               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [LEN_W-1:0]     cnt_q;
  logic                 en_q;
  logic                 err_q;

  logic [IDX_W-1:0]     gnt_idx_c;
  logic                 gnt_onehot_c;
  logic [NUM_PORTS-1:0] owner_oh_c;
  logic [NUM_PORTS-1:0] req_c;
  logic [NUM_PORTS-1:0] ready_c;
  logic                 bus_valid_c;
  logic [DATA_W-1:0]    bus_data_c;
  logic [IDX_W-1:0]     bus_port_c;
  logic                 bus_last_c;
  logic                 fire_c;
  logic                 grant_ok_c;
  logic                 grant_bad_c;

  arb_grant_lock_oh2idx #(.N(NUM_PORTS)) u_oh2idx (
    .oh        (bif.arb_gnt_i),
    .idx       (gnt_idx_c),
    .is_onehot (gnt_onehot_c)
  );

  assign owner_oh_c = NUM_PORTS'(1) << owner_q;

  // Request masking and bus mux; the bus is driven to zero while idle.
  always_comb begin
    req_c       = '0;
    ready_c     = '0;
    bus_valid_c = 1'b0;
    bus_data_c  = '0;
    bus_port_c  = '0;
    bus_last_c  = 1'b0;
    if (state_q == IDLE) begin
      req_c = bif.cli_valid_i & {NUM_PORTS{en_q}};
    end else begin
      req_c       = owner_oh_c;
      bus_valid_c = bif.cli_valid_i[owner_q];
      bus_data_c  = bif.cli_data_i[owner_q*DATA_W +: DATA_W];
      bus_port_c  = owner_q;
      ready_c     = owner_oh_c & {NUM_PORTS{bif.bus_ready_i}};
      bus_last_c  = (cnt_q == '0) && bus_valid_c;
    end
  end

  assign fire_c      = bus_valid_c && bif.bus_ready_i;
  assign grant_ok_c  = gnt_onehot_c && ((bif.arb_gnt_i & req_c) != '0);
  assign grant_bad_c = (bif.arb_gnt_i != '0) && !grant_ok_c;

  // Grant capture, beat countdown and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (state_q == IDLE) begin
        if (grant_ok_c) begin
          state_q <= OWN;
          owner_q <= gnt_idx_c;
          cnt_q   <= bif.cli_len_i[gnt_idx_c*LEN_W +: LEN_W];
        end else if (grant_bad_c) begin
          err_q <= 1'b1;
        end
      end else if (fire_c) begin
        if (cnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - LEN_W'(1);
        end
      end
    end
  end

  assign bif.arb_req_o   = req_c;
  assign bif.cli_ready_o = ready_c;
  assign bif.bus_valid_o = bus_valid_c;
  assign bif.bus_data_o  = bus_data_c;
  assign bif.bus_port_o  = bus_port_c;
  assign bif.bus_last_o  = bus_last_c;
  assign bif.err_o       = err_q;

endmodule

// File: tb/tb_arb_grant_lock.sv
// Bench for arb_grant_lock: directed scenarios plus a randomized run against a
// burst-level reference model; a lowest-index arbiter stands in for arb_v1.
module tb_arb_grant_lock;
  import arb_grant_lock_pkg::*;

  localparam int unsigned NP = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_en = 1'b0;
  logic [7:0] force_gnt = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  arb_grant_lock_if #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) bif ();

  arb_grant_lock #(.NUM_PORTS(NP), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif.slave)
  );

  // Stand-in arbiter: lowest requesting index wins, unless a grant is forced.
  always_comb begin
    if (force_en) bif.arb_gnt_i = force_gnt;
    else          bif.arb_gnt_i = bif.arb_req_o & (~bif.arb_req_o + 8'd1);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [LW-1:0] len, input logic [DW-1:0] data);
    bif.cli_len_i[p*LW +: LW]  = len;
    bif.cli_data_i[p*DW +: DW] = data;
  endtask

  task automatic do_reset();
    bif.cli_valid_i = '0;
    bif.bus_ready_i = 1'b0;
    force_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_reset();
    bif.cli_valid_i = 8'hFF;
    bif.cli_len_i   = '0;
    bif.cli_data_i  = {8{32'hDEAD_BEEF}};
    bif.bus_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.arb_req_o !== 8'h00) begin errors++; $display("FAIL rst_req: got %h exp 00", bif.arb_req_o); end
    checks++; if (bif.cli_ready_o !== 8'h00) begin errors++; $display("FAIL rst_ready: got %h exp 00", bif.cli_ready_o); end
    checks++; if ({bif.bus_valid_o, bif.bus_last_o, bif.err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {bif.bus_valid_o, bif.bus_last_o, bif.err_o}); end
    checks++; if ({bif.bus_data_o, bif.bus_port_o} !== '0) begin errors++; $display("FAIL rst_bus: got %h/%0d exp 0/0", bif.bus_data_o, bif.bus_port_o); end
    rst_n = 1'b1;
    #2;
    checks++; if (bif.arb_req_o !== 8'h00) begin errors++; $display("FAIL req_first_cycle: got %h exp 00", bif.arb_req_o); end
    next_cyc();
    checks++; if (bif.arb_req_o !== 8'hFF) begin errors++; $display("FAIL req_enabled: got %h exp ff", bif.arb_req_o); end
    bif.cli_valid_i = '0;
    next_cyc();
    checks++; if (bif.bus_valid_o !== 1'b0) begin errors++; $display("FAIL rst_still_idle: got %b exp 0", bif.bus_valid_o); end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    for (int p = 0; p < int'(NP); p++) set_port(p, 4'($urandom), $urandom);
    set_port(4, 4'd3, d[0]);
    bif.bus_ready_i = 1'b1;
    bif.cli_valid_i = 8'b1011_0000;
    @(negedge clk);
    checks++; if (bif.arb_req_o !== 8'b1011_0000) begin errors++; $display("FAIL sb_idle_req: got %b exp 10110000", bif.arb_req_o); end
    next_cyc();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++; if (bif.bus_valid_o !== 1'b1 || bif.bus_port_o !== 3'd4) begin errors++; $display("FAIL sb_beat%0d_vp: got v=%b p=%0d exp v=1 p=4", b, bif.bus_valid_o, bif.bus_port_o); end
      checks++; if (bif.bus_data_o !== d[b]) begin errors++; $display("FAIL sb_beat%0d_data: got %h exp %h", b, bif.bus_data_o, d[b]); end
      checks++; if (bif.bus_last_o !== (b == 3)) begin errors++; $display("FAIL sb_beat%0d_last: got %b exp %b", b, bif.bus_last_o, (b == 3)); end
      checks++; if (bif.arb_req_o !== 8'b0001_0000 || bif.cli_ready_o !== 8'b0001_0000) begin errors++; $display("FAIL sb_beat%0d_mask: got req=%b rdy=%b exp 00010000", b, bif.arb_req_o, bif.cli_ready_o); end
      next_cyc();
      set_port(4, 4'($urandom), d[b+1]);
    end
    bif.cli_valid_i = '0;
    @(negedge clk);
    checks++; if ({bif.bus_valid_o, bif.arb_req_o, bif.bus_data_o, bif.bus_port_o} !== '0) begin errors++; $display("FAIL sb_back_idle: got v=%b req=%h d=%h p=%0d exp zeros", bif.bus_valid_o, bif.arb_req_o, bif.bus_data_o, bif.bus_port_o); end
    next_cyc();
  endtask

  task automatic test_backpressure();
    logic [3:0]    pat = 4'b1001;
    logic [DW-1:0] d [3];
    int            beat = 0;
    int            fires = 0;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    set_port(7, 4'd1, d[0]);
    bif.bus_ready_i = 1'b0;
    bif.cli_valid_i = 8'b1000_0000;
    next_cyc();
    for (int c = 0; c < 4; c++) begin
      bif.bus_ready_i = pat[c];
      @(negedge clk);
      checks++; if (bif.bus_valid_o !== 1'b1 || bif.bus_data_o !== d[beat]) begin errors++; $display("FAIL bp_c%0d_data: got v=%b d=%h exp v=1 d=%h", c, bif.bus_valid_o, bif.bus_data_o, d[beat]); end
      checks++; if (bif.cli_ready_o !== {pat[c], 7'b0}) begin errors++; $display("FAIL bp_c%0d_ready: got %b exp %b", c, bif.cli_ready_o, {pat[c], 7'b0}); end
      checks++; if (bif.bus_last_o !== (beat == 1)) begin errors++; $display("FAIL bp_c%0d_last: got %b exp %b", c, bif.bus_last_o, (beat == 1)); end
      if (bif.bus_valid_o && bif.bus_ready_i) fires++;
      next_cyc();
      if (pat[c]) begin
        beat++;
        set_port(7, 4'd1, d[beat]);
      end
    end
    bif.cli_valid_i = '0;
    @(negedge clk);
    checks++; if (fires !== 2) begin errors++; $display("FAIL bp_fires: got %0d exp 2", fires); end
    checks++; if (bif.bus_valid_o !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b exp 0", bif.bus_valid_o); end
    next_cyc();
  endtask

  task automatic test_client_stall();
    logic [6:0] vpat = 7'b1100011;
    int         beats = 0;
    set_port(5, 4'd3, 32'h5000_0000);
    bif.bus_ready_i = 1'b1;
    bif.cli_valid_i = 8'b0010_0000;
    next_cyc();
    for (int c = 0; c < 7; c++) begin
      bif.cli_valid_i = {2'b00, vpat[c], 5'b0};
      set_port(5, 4'($urandom), 32'h5000_0000 + 32'(beats));
      @(negedge clk);
      checks++; if (bif.bus_valid_o !== vpat[c]) begin errors++; $display("FAIL st_c%0d_valid: got %b exp %b", c, bif.bus_valid_o, vpat[c]); end
      checks++; if (bif.bus_last_o !== (vpat[c] && beats == 3)) begin errors++; $display("FAIL st_c%0d_last: got %b exp %b", c, bif.bus_last_o, (vpat[c] && beats == 3)); end
      checks++; if (bif.arb_req_o !== 8'b0010_0000) begin errors++; $display("FAIL st_c%0d_req: got %b exp 00100000", c, bif.arb_req_o); end
      if (bif.bus_valid_o && bif.bus_ready_i) beats++;
      next_cyc();
    end
    bif.cli_valid_i = '0;
    @(negedge clk);
    checks++; if (beats !== 4) begin errors++; $display("FAIL st_beats: got %0d exp 4", beats); end
    checks++; if (bif.bus_valid_o !== 1'b0 || bif.arb_req_o !== 8'h00) begin errors++; $display("FAIL st_idle: got v=%b req=%h exp 0/00", bif.bus_valid_o, bif.arb_req_o); end
    next_cyc();
  endtask

  // Burst-level reference model: owner plus beats still to transfer.
  task automatic test_random();
    logic [7:0]    v, e_req, e_rdy, m_gnt;
    logic [LW-1:0] lens [NP];
    logic [DW-1:0] datas [NP];
    logic          br, e_valid, e_last;
    logic [DW-1:0] e_data;
    int            m_owner = 0;
    int            m_left = 0;
    bit            m_own = 1'b0;
    bit            stalled = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin lens[p] = '0; datas[p] = '0; end
    for (int i = 0; i < 300; i++) begin
      v  = 8'($urandom) & 8'($urandom);
      br = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < int'(NP); p++) begin
        lens[p] = 4'($urandom);
        if (!(stalled && m_own && m_owner == p)) datas[p] = $urandom;
        set_port(p, lens[p], datas[p]);
      end
      bif.cli_valid_i = v;
      bif.bus_ready_i = br;
      e_req   = m_own ? (8'd1 << m_owner) : v;
      e_valid = m_own && v[m_owner];
      e_data  = m_own ? datas[m_owner] : '0;
      e_last  = e_valid && (m_left == 1);
      e_rdy   = (m_own && br) ? (8'd1 << m_owner) : 8'd0;
      @(negedge clk);
      checks++; if (bif.arb_req_o !== e_req) begin errors++; $display("FAIL rnd%0d_req: got %b exp %b", i, bif.arb_req_o, e_req); end
      checks++; if (bif.bus_valid_o !== e_valid || bif.bus_last_o !== e_last) begin errors++; $display("FAIL rnd%0d_vl: got v=%b l=%b exp v=%b l=%b", i, bif.bus_valid_o, bif.bus_last_o, e_valid, e_last); end
      checks++; if (bif.bus_data_o !== e_data || bif.bus_port_o !== 3'(m_own ? m_owner : 0)) begin errors++; $display("FAIL rnd%0d_bus: got d=%h p=%0d exp d=%h p=%0d", i, bif.bus_data_o, bif.bus_port_o, e_data, m_own ? m_owner : 0); end
      checks++; if (bif.cli_ready_o !== e_rdy) begin errors++; $display("FAIL rnd%0d_ready: got %b exp %b", i, bif.cli_ready_o, e_rdy); end
      checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL rnd%0d_err: got %b exp 0", i, bif.err_o); end
      @(posedge clk);
      if (!m_own) begin
        m_gnt = e_req & (~e_req + 8'd1);
        for (int p = 0; p < int'(NP); p++) begin
          if (m_gnt[p]) begin
            m_own = 1'b1;
            m_owner = p;
            m_left = int'(lens[p]) + 1;
          end
        end
        stalled = 1'b0;
      end else begin
        stalled = e_valid && !br;
        if (e_valid && br) begin
          m_left--;
          if (m_left == 0) m_own = 1'b0;
        end
      end
      #1;
    end
    bif.cli_valid_i = '0;
  endtask

  task automatic test_bad_grant();
    do_reset();
    bif.cli_valid_i = 8'b0000_0011;
    force_gnt = 8'b0000_0011;
    force_en = 1'b1;
    @(negedge clk);
    checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL bg_err_before: got %b exp 0", bif.err_o); end
    next_cyc();
    checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL bg_multi_err: got %b exp 1", bif.err_o); end
    checks++; if (bif.bus_valid_o !== 1'b0 || bif.arb_req_o !== 8'b0000_0011) begin errors++; $display("FAIL bg_multi_idle: got v=%b req=%b exp 0/00000011", bif.bus_valid_o, bif.arb_req_o); end
    do_reset();
    checks++; if (bif.err_o !== 1'b0) begin errors++; $display("FAIL bg_err_cleared: got %b exp 0", bif.err_o); end
    bif.cli_valid_i = 8'b0000_0010;
    force_gnt = 8'b0000_0001;
    force_en = 1'b1;
    next_cyc();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL bg_nonreq_err%0d: got %b exp 1", c, bif.err_o); end
      checks++; if (bif.bus_valid_o !== 1'b0 || bif.arb_req_o !== 8'b0000_0010) begin errors++; $display("FAIL bg_nonreq_idle%0d: got v=%b req=%b exp 0/00000010", c, bif.bus_valid_o, bif.arb_req_o); end
      next_cyc();
    end
    force_en = 1'b0;
    bif.cli_valid_i = '0;
    next_cyc();
    checks++; if (bif.err_o !== 1'b1) begin errors++; $display("FAIL bg_sticky: got %b exp 1", bif.err_o); end
  endtask

  task automatic test_async_reset();
    int beats = 0;
    do_reset();
    set_port(2, 4'd3, 32'h2000_0000);
    bif.bus_ready_i = 1'b1;
    bif.cli_valid_i = 8'b0000_0100;
    next_cyc();
    next_cyc();
    @(negedge clk);
    checks++; if (bif.bus_valid_o !== 1'b1 || bif.bus_last_o !== 1'b0) begin errors++; $display("FAIL ar_beat2: got v=%b l=%b exp 1/0", bif.bus_valid_o, bif.bus_last_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bif.bus_valid_o, bif.arb_req_o, bif.cli_ready_o, bif.bus_data_o, bif.bus_port_o} !== '0) begin errors++; $display("FAIL ar_immediate: got v=%b req=%h rdy=%h d=%h exp zeros", bif.bus_valid_o, bif.arb_req_o, bif.cli_ready_o, bif.bus_data_o); end
    #1 rst_n = 1'b1;
    next_cyc();
    @(negedge clk);
    checks++; if (bif.arb_req_o !== 8'b0000_0100 || bif.bus_valid_o !== 1'b0) begin errors++; $display("FAIL ar_rerequest: got req=%b v=%b exp 00000100/0", bif.arb_req_o, bif.bus_valid_o); end
    next_cyc();
    for (int c = 0; c < 6 && beats < 4; c++) begin
      @(negedge clk);
      checks++; if (bif.bus_last_o !== (bif.bus_valid_o && beats == 3)) begin errors++; $display("FAIL ar_last%0d: got %b exp %b", beats, bif.bus_last_o, (beats == 3)); end
      if (bif.bus_valid_o && bif.bus_ready_i) beats++;
      next_cyc();
    end
    bif.cli_valid_i = '0;
    checks++; if (beats !== 4) begin errors++; $display("FAIL ar_full_len: got %0d beats exp 4", beats); end
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_client_stall();
    test_random();
    test_bad_grant();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
